id_ex_stage: RTL and testbench

- Decode-to-execute pipeline stage sitting directly downstream of the register file in the 5-stage RISC-V core.
- Merges the register-file read data with a same-cycle writeback bypass, because the register file writes at posedge and reads combinationally.
- Detects load-use hazards, inserts bubbles, and honours flush and hold requests.
- Registers the operand bundle consumed by EX and keeps a saturating load-use stall counter.

---
 rtl/id_ex_stage_if.sv | 56 +++++
 rtl/id_ex_stage.sv | 102 ++++++++++
 tb/tb_id_ex_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: ID fields, register-file read data and writeback
// bypass in; registered EX operand bundle, stall request and bubble count out.
interface id_ex_stage_if #(
  parameter int CTRL_W = 16
);
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_imm;
  logic [4:0]        id_rs1_index;
  logic [4:0]        id_rs2_index;
  logic [4:0]        id_rd_index;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic              id_mem_read;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       rs1_data_in;
  logic [31:0]       rs2_data_in;
  logic              wb_en;
  logic [4:0]        wb_rd_index;
  logic [31:0]       wb_data;
  logic              flush;
  logic              ex_hold;

  logic              id_stall;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_imm;
  logic [31:0]       ex_rs1_data;
  logic [31:0]       ex_rs2_data;
  logic [4:0]        ex_rs1_index;
  logic [4:0]        ex_rs2_index;
  logic [4:0]        ex_rd_index;
  logic              ex_mem_read;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       stall_cnt;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1_index, id_rs2_index, id_rd_index,
           id_uses_rs1, id_uses_rs2, id_mem_read, id_ctrl,
           rs1_data_in, rs2_data_in, wb_en, wb_rd_index, wb_data,
           flush, ex_hold,
    input  id_stall, ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data,
           ex_rs1_index, ex_rs2_index, ex_rd_index, ex_mem_read, ex_ctrl,
           stall_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1_index, id_rs2_index, id_rd_index,
           id_uses_rs1, id_uses_rs2, id_mem_read, id_ctrl,
           rs1_data_in, rs2_data_in, wb_en, wb_rd_index, wb_data,
           flush, ex_hold,
    output id_stall, ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data,
           ex_rs1_index, ex_rs2_index, ex_rd_index, ex_mem_read, ex_ctrl,
           stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle writeback bypass, load-use bubble
// insertion, flush/hold handling and a saturating load-use bubble counter.
module id_ex_stage #(
  parameter int CTRL_W = 16
) (
  input logic           clk,
  input logic           rst,
  id_ex_stage_if.slave  bus
);

  logic              r_ex_valid;
  logic [31:0]       r_ex_pc;
  logic [31:0]       r_ex_imm;
  logic [31:0]       r_ex_rs1_data;
  logic [31:0]       r_ex_rs2_data;
  logic [4:0]        r_ex_rs1_index;
  logic [4:0]        r_ex_rs2_index;
  logic [4:0]        r_ex_rd_index;
  logic              r_ex_mem_read;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [31:0]       r_stall_cnt;

  logic [31:0]       w_op1;
  logic [31:0]       w_op2;
  logic              w_hazard;

  // The register file writes at posedge, so a same-cycle writeback must be bypassed here.
  always_comb begin
    w_op1 = bus.rs1_data_in;
    if (bus.id_rs1_index == 5'd0)
      w_op1 = 32'd0;
    else if (bus.wb_en && (bus.wb_rd_index == bus.id_rs1_index))
      w_op1 = bus.wb_data;

    w_op2 = bus.rs2_data_in;
    if (bus.id_rs2_index == 5'd0)
      w_op2 = 32'd0;
    else if (bus.wb_en && (bus.wb_rd_index == bus.id_rs2_index))
      w_op2 = bus.wb_data;
  end

  assign w_hazard = r_ex_valid && r_ex_mem_read && (r_ex_rd_index != 5'd0) &&
                    bus.id_valid &&
                    ((bus.id_uses_rs1 && (bus.id_rs1_index == r_ex_rd_index)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2_index == r_ex_rd_index)));

  assign bus.id_stall = bus.ex_hold || w_hazard;

  // Flush outranks hold; a bubble only clears the fields EX acts on.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= 32'd0;
      r_ex_imm       <= 32'd0;
      r_ex_rs1_data  <= 32'd0;
      r_ex_rs2_data  <= 32'd0;
      r_ex_rs1_index <= 5'd0;
      r_ex_rs2_index <= 5'd0;
      r_ex_rd_index  <= 5'd0;
      r_ex_mem_read  <= 1'b0;
      r_ex_ctrl      <= '0;
      r_stall_cnt    <= 32'd0;
    end else if (bus.flush) begin
      r_ex_valid    <= 1'b0;
      r_ex_mem_read <= 1'b0;
      r_ex_rd_index <= 5'd0;
    end else if (bus.ex_hold) begin
      r_ex_valid <= r_ex_valid;
    end else if (w_hazard) begin
      r_ex_valid    <= 1'b0;
      r_ex_mem_read <= 1'b0;
      r_ex_rd_index <= 5'd0;
      r_ex_ctrl     <= '0;
      if (r_stall_cnt != 32'hFFFF_FFFF)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_ex_valid     <= bus.id_valid;
      r_ex_pc        <= bus.id_pc;
      r_ex_imm       <= bus.id_imm;
      r_ex_rs1_data  <= w_op1;
      r_ex_rs2_data  <= w_op2;
      r_ex_rs1_index <= bus.id_rs1_index;
      r_ex_rs2_index <= bus.id_rs2_index;
      r_ex_rd_index  <= bus.id_rd_index;
      r_ex_mem_read  <= bus.id_mem_read;
      r_ex_ctrl      <= bus.id_ctrl;
    end
  end

  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_pc        = r_ex_pc;
  assign bus.ex_imm       = r_ex_imm;
  assign bus.ex_rs1_data  = r_ex_rs1_data;
  assign bus.ex_rs2_data  = r_ex_rs2_data;
  assign bus.ex_rs1_index = r_ex_rs1_index;
  assign bus.ex_rs2_index = r_ex_rs2_index;
  assign bus.ex_rd_index  = r_ex_rd_index;
  assign bus.ex_mem_read  = r_ex_mem_read;
  assign bus.ex_ctrl      = r_ex_ctrl;
  assign bus.stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, bypass, load-use bubble, flush/hold,
// false-hazard filtering and stall counter saturation.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;

  id_ex_stage_if #(.CTRL_W(16)) bus ();

  id_ex_stage #(.CTRL_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID instruction; immediate is derived from pc so it is checkable.
  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic u1,
                               input logic u2, input logic memrd,
                               input logic [15:0] ctrl);
    bus.id_valid     = valid;
    bus.id_pc        = pc;
    bus.id_imm       = pc ^ 32'hFFFF_0000;
    bus.id_rs1_index = rs1;
    bus.id_rs2_index = rs2;
    bus.id_rd_index  = rd;
    bus.id_uses_rs1  = u1;
    bus.id_uses_rs2  = u2;
    bus.id_mem_read  = memrd;
    bus.id_ctrl      = ctrl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    bus.rs1_data_in = 32'd0;
    bus.rs2_data_in = 32'd0;
    bus.wb_en       = 1'b0;
    bus.wb_rd_index = 5'd0;
    bus.wb_data     = 32'd0;
    bus.flush       = 1'b0;
    bus.ex_hold     = 1'b0;
    stepClock();

    // Load nonzero state, then reset for two cycles
    rst = 1'b1;
    applyStimulus(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 16'hABCD);
    bus.rs1_data_in = 32'h1111_1111;
    stepClock();
    checkOutput("capture_valid", {31'd0, bus.ex_valid}, 32'd1);
    checkOutput("capture_pc", bus.ex_pc, 32'h100);
    checkOutput("capture_imm", bus.ex_imm, 32'hFFFF_0100);
    checkOutput("capture_ctrl", {16'd0, bus.ex_ctrl}, 32'h0000_ABCD);
    checkOutput("capture_rs1data", bus.ex_rs1_data, 32'h1111_1111);
    rst = 1'b0;
    stepClock();
    stepClock();
    checkOutput("reset_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("reset_pc", bus.ex_pc, 32'd0);
    checkOutput("reset_rd", {27'd0, bus.ex_rd_index}, 32'd0);
    checkOutput("reset_memrd", {31'd0, bus.ex_mem_read}, 32'd0);
    checkOutput("reset_ctrl", {16'd0, bus.ex_ctrl}, 32'd0);
    checkOutput("reset_rs1data", bus.ex_rs1_data, 32'd0);
    checkOutput("reset_stallcnt", bus.stall_cnt, 32'd0);
    checkOutput("reset_idstall", {31'd0, bus.id_stall}, 32'd0);

    // Writeback bypass beats register file; x0 never bypassed
    rst = 1'b1;
    applyStimulus(1'b1, 32'h110, 5'd5, 5'd9, 5'd7, 1'b1, 1'b1, 1'b0, 16'h0001);
    bus.rs1_data_in = 32'h0000_0011;
    bus.rs2_data_in = 32'h0000_0022;
    bus.wb_en       = 1'b1;
    bus.wb_rd_index = 5'd5;
    bus.wb_data     = 32'hDEAD_BEEF;
    stepClock();
    checkOutput("bypass_rs1", bus.ex_rs1_data, 32'hDEAD_BEEF);
    checkOutput("nobypass_rs2", bus.ex_rs2_data, 32'h0000_0022);
    applyStimulus(1'b1, 32'h114, 5'd0, 5'd9, 5'd7, 1'b1, 1'b1, 1'b0, 16'h0001);
    bus.rs1_data_in = 32'h0000_0055;
    bus.wb_rd_index = 5'd0;
    stepClock();
    checkOutput("x0_reads_zero", bus.ex_rs1_data, 32'd0);
    applyStimulus(1'b1, 32'h118, 5'd5, 5'd9, 5'd7, 1'b1, 1'b1, 1'b0, 16'h0001);
    bus.rs1_data_in = 32'h0000_0011;
    bus.wb_en       = 1'b0;
    bus.wb_rd_index = 5'd5;
    stepClock();
    checkOutput("wb_disabled_rf", bus.ex_rs1_data, 32'h0000_0011);
    checkOutput("rs1_index", {27'd0, bus.ex_rs1_index}, 32'd5);

    // Load-use: lw x6 then add using rs2=x6
    applyStimulus(1'b1, 32'h200, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 16'h0002);
    stepClock();
    checkOutput("lw_memrd", {31'd0, bus.ex_mem_read}, 32'd1);
    checkOutput("lw_rd", {27'd0, bus.ex_rd_index}, 32'd6);
    applyStimulus(1'b1, 32'h204, 5'd2, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 16'h1234);
    #1;
    checkOutput("loaduse_stall", {31'd0, bus.id_stall}, 32'd1);
    stepClock();
    checkOutput("bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("bubble_ctrl", {16'd0, bus.ex_ctrl}, 32'd0);
    checkOutput("bubble_rd", {27'd0, bus.ex_rd_index}, 32'd0);
    checkOutput("bubble_cnt", bus.stall_cnt, 32'd1);
    checkOutput("stall_cleared", {31'd0, bus.id_stall}, 32'd0);
    stepClock();
    checkOutput("add_valid", {31'd0, bus.ex_valid}, 32'd1);
    checkOutput("add_pc", bus.ex_pc, 32'h204);
    checkOutput("add_rd", {27'd0, bus.ex_rd_index}, 32'd8);
    checkOutput("add_cnt", bus.stall_cnt, 32'd1);

    // Flush overrides hold
    bus.flush   = 1'b1;
    bus.ex_hold = 1'b1;
    #1;
    checkOutput("flushhold_stall", {31'd0, bus.id_stall}, 32'd1);
    stepClock();
    checkOutput("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b0;
    applyStimulus(1'b1, 32'h300, 5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 1'b0, 16'h0003);
    stepClock();
    checkOutput("pre_hold_pc", bus.ex_pc, 32'h300);

    // Hold three cycles with new ID contents waiting
    bus.ex_hold = 1'b1;
    applyStimulus(1'b1, 32'h400, 5'd3, 5'd4, 5'd11, 1'b1, 1'b1, 1'b0, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("hold_stall", {31'd0, bus.id_stall}, 32'd1);
      stepClock();
      checkOutput("hold_pc", bus.ex_pc, 32'h300);
      checkOutput("hold_valid", {31'd0, bus.ex_valid}, 32'd1);
      checkOutput("hold_rd", {27'd0, bus.ex_rd_index}, 32'd10);
    end
    bus.ex_hold = 1'b0;
    stepClock();
    checkOutput("post_hold_pc", bus.ex_pc, 32'h400);

    // No false hazards: unused rs2, load to x0, invalid ID
    applyStimulus(1'b1, 32'h500, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 16'h0005);
    stepClock();
    applyStimulus(1'b1, 32'h504, 5'd3, 5'd6, 5'd9, 1'b1, 1'b0, 1'b0, 16'h0006);
    #1;
    checkOutput("unused_rs2_nostall", {31'd0, bus.id_stall}, 32'd0);
    stepClock();
    checkOutput("unused_rs2_valid", {31'd0, bus.ex_valid}, 32'd1);
    checkOutput("unused_rs2_cnt", bus.stall_cnt, 32'd1);
    applyStimulus(1'b1, 32'h508, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 16'h0007);
    stepClock();
    applyStimulus(1'b1, 32'h50C, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 16'h0008);
    #1;
    checkOutput("lw_x0_nostall", {31'd0, bus.id_stall}, 32'd0);
    applyStimulus(1'b1, 32'h510, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 16'h0009);
    stepClock();
    applyStimulus(1'b0, 32'h514, 5'd6, 5'd6, 5'd9, 1'b1, 1'b1, 1'b0, 16'h000A);
    #1;
    checkOutput("invalid_id_nostall", {31'd0, bus.id_stall}, 32'd0);
    stepClock();
    checkOutput("invalid_id_cnt", bus.stall_cnt, 32'd1);

    // Saturation of the bubble counter
    applyStimulus(1'b1, 32'h600, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 16'h000B);
    stepClock();
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    applyStimulus(1'b1, 32'h604, 5'd6, 5'd2, 5'd12, 1'b1, 1'b1, 1'b0, 16'h000C);
    #1;
    checkOutput("sat_stall", {31'd0, bus.id_stall}, 32'd1);
    stepClock();
    checkOutput("sat_cnt", bus.stall_cnt, 32'hFFFF_FFFF);
    checkOutput("sat_bubble", {31'd0, bus.ex_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
